// File: rtl/alarm_pkg.sv
// Shared types, limits and BCD increment helpers for the alarm-time controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RING   = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX        = 4'd9;
  localparam logic [BCD_W-1:0] MIN_U_MAX      = 4'd9;
  localparam logic [BCD_W-1:0] MIN_T_MAX      = 4'd5;
  localparam logic [BCD_W-1:0] HR_T_MAX       = 4'd2;
  localparam logic [BCD_W-1:0] HR_U_MAX_AT_T2 = 4'd3;

  // HH:MM as four BCD digits, d3 = hour tens ... d0 = minute units
  typedef struct packed {
    logic [BCD_W-1:0] d3;
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } hhmm_t;

  // Minute field advance, 59 -> 00, hours untouched
  function automatic hhmm_t min_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.d0 >= MIN_U_MAX) begin
      r.d0 = '0;
      r.d1 = (t.d1 >= MIN_T_MAX) ? '0 : BCD_W'(t.d1 + 4'd1);
    end else begin
      r.d0 = BCD_W'(t.d0 + 4'd1);
    end
    return r;
  endfunction

  // Hour field advance, 23 -> 00, minutes untouched
  function automatic hhmm_t hr_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if ((t.d3 == HR_T_MAX) && (t.d2 >= HR_U_MAX_AT_T2)) begin
      r.d3 = '0;
      r.d2 = '0;
    end else if (t.d2 >= BCD_MAX) begin
      r.d2 = '0;
      r.d3 = BCD_W'(t.d3 + 4'd1);
    end else begin
      r.d2 = BCD_W'(t.d2 + 4'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_ctrl_btn_edge.sv
// Turns a synchronized, debounced button level into a one-cycle rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise_c
);

  logic r_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lvl <= 1'b0;
    else        r_lvl <= i_lvl;
  end

  assign o_rise_c = i_lvl & ~r_lvl;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-time register, set/arm mode FSM, time compare and ring/snooze sequencing.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       sec_zero,
  input  logic [3:0] t_d0,
  input  logic [3:0] t_d1,
  input  logic [3:0] t_d2,
  input  logic [3:0] t_d3,
  input  logic       btn_min,
  input  logic       btn_hora,
  input  logic       btn_set,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [3:0] a_d0,
  output logic [3:0] a_d1,
  output logic [3:0] a_d2,
  output logic [3:0] a_d3,
  output logic       setting,
  output logic       armed,
  output logic       ringing
);

  logic w_min_rise, w_hora_rise, w_set_rise, w_stop_rise, w_snooze_rise;

  btn_edge u_min    (.clk(clk), .rst_n(rst_n), .i_lvl(btn_min),    .o_rise_c(w_min_rise));
  btn_edge u_hora   (.clk(clk), .rst_n(rst_n), .i_lvl(btn_hora),   .o_rise_c(w_hora_rise));
  btn_edge u_set    (.clk(clk), .rst_n(rst_n), .i_lvl(btn_set),    .o_rise_c(w_set_rise));
  btn_edge u_stop   (.clk(clk), .rst_n(rst_n), .i_lvl(btn_stop),   .o_rise_c(w_stop_rise));
  btn_edge u_snooze (.clk(clk), .rst_n(rst_n), .i_lvl(btn_snooze), .o_rise_c(w_snooze_rise));

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  hhmm_t              r_alarm, w_alarm_nxt;
  logic               r_setting, r_armed, r_ringing;
  logic               w_setting_nxt, w_armed_nxt, w_ringing_nxt;
  hhmm_t              w_time;
  logic               w_trigger, w_ring_done, w_snooze_done;

  assign w_time = {t_d3, t_d2, t_d1, t_d0};

  // The sec_zero qualifier limits the match to one tick per minute
  assign w_trigger     = tick_1hz & sec_zero & (w_time == r_alarm);
  assign w_ring_done   = tick_1hz & (r_cnt == CNT_W'(RING_SECS - 1));
  assign w_snooze_done = tick_1hz & (r_cnt == CNT_W'(SNOOZE_SECS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_alarm_nxt = r_alarm;

    unique case (r_state)
      ST_IDLE: begin
        if (w_set_rise) w_state_nxt = ST_SET;
      end
      ST_SET: begin
        // Minute and hour fields are disjoint, so both presses may land together
        if (w_min_rise)  w_alarm_nxt = min_inc(w_alarm_nxt);
        if (w_hora_rise) w_alarm_nxt = hr_inc(w_alarm_nxt);
        if (w_set_rise)  w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_set_rise)     w_state_nxt = ST_IDLE;
        else if (w_trigger) w_state_nxt = ST_RING;
      end
      ST_RING: begin
        if (w_stop_rise)        w_state_nxt = ST_ARMED;
        else if (w_snooze_rise) w_state_nxt = ST_SNOOZE;
        else if (w_ring_done)   w_state_nxt = ST_ARMED;
        else if (tick_1hz)      w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_SNOOZE: begin
        if (w_stop_rise)        w_state_nxt = ST_ARMED;
        else if (w_snooze_done) w_state_nxt = ST_RING;
        else if (tick_1hz)      w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;

    w_setting_nxt = (w_state_nxt == ST_SET);
    w_ringing_nxt = (w_state_nxt == ST_RING);
    w_armed_nxt   = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_RING) ||
                    (w_state_nxt == ST_SNOOZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_alarm   <= '0;
      r_setting <= 1'b0;
      r_armed   <= 1'b0;
      r_ringing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_alarm   <= w_alarm_nxt;
      r_setting <= w_setting_nxt;
      r_armed   <= w_armed_nxt;
      r_ringing <= w_ringing_nxt;
    end
  end

  assign a_d0    = r_alarm.d0;
  assign a_d1    = r_alarm.d1;
  assign a_d2    = r_alarm.d2;
  assign a_d3    = r_alarm.d3;
  assign setting = r_setting;
  assign armed   = r_armed;
  assign ringing = r_ringing;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed sequences then random stimulus vs a behavioural model.
module tb_alarm_ctrl;

  localparam int RING_N   = 4;
  localparam int SNOOZE_N = 5;

  localparam int B_MIN = 0, B_HORA = 1, B_SET = 2, B_STOP = 3, B_SNOOZE = 4;
  localparam int M_IDLE = 0, M_SET = 1, M_ARMED = 2, M_RING = 3, M_SNOOZE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       sz = 1'b0;
  logic [4:0] btns = '0;
  int         t_h = 0, t_m = 0;

  logic [3:0] t_d0, t_d1, t_d2, t_d3;
  logic [3:0] a_d0, a_d1, a_d2, a_d3;
  logic       setting, armed, ringing;

  assign t_d0 = 4'(t_m % 10);
  assign t_d1 = 4'(t_m / 10);
  assign t_d2 = 4'(t_h % 10);
  assign t_d3 = 4'(t_h / 10);

  alarm_ctrl #(.RING_SECS(RING_N), .SNOOZE_SECS(SNOOZE_N)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick), .sec_zero(sz),
    .t_d0(t_d0), .t_d1(t_d1), .t_d2(t_d2), .t_d3(t_d3),
    .btn_min(btns[B_MIN]), .btn_hora(btns[B_HORA]), .btn_set(btns[B_SET]),
    .btn_stop(btns[B_STOP]), .btn_snooze(btns[B_SNOOZE]),
    .a_d0(a_d0), .a_d1(a_d1), .a_d2(a_d2), .a_d3(a_d3),
    .setting(setting), .armed(armed), .ringing(ringing)
  );

  always #5 clk = ~clk;

  // Behavioural model: alarm as plain hour/minute integers, ringing as elapsed ticks
  int         m_mode = M_IDLE;
  int         m_ah = 0, m_am = 0, m_secs = 0;
  logic [4:0] m_prev = '0;
  int         cyc = 0;

  logic [18:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [18:0] pack(int h, int m, int md);
    logic s, a, r;
    s = (md == M_SET);
    a = (md == M_ARMED) || (md == M_RING) || (md == M_SNOOZE);
    r = (md == M_RING);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), s, a, r};
  endfunction

  task automatic model_step();
    logic [4:0] e;
    bit         trig;
    if (!rst_n) begin
      m_mode = M_IDLE; m_ah = 0; m_am = 0; m_secs = 0; m_prev = '0;
      return;
    end
    e    = btns & ~m_prev;
    trig = tick && sz && (t_h * 60 + t_m == m_ah * 60 + m_am);
    case (m_mode)
      M_IDLE:  if (e[B_SET]) m_mode = M_SET;
      M_SET: begin
        if (e[B_MIN])  m_am = (m_am + 1) % 60;
        if (e[B_HORA]) m_ah = (m_ah + 1) % 24;
        if (e[B_SET])  m_mode = M_ARMED;
      end
      M_ARMED: begin
        if (e[B_SET]) m_mode = M_IDLE;
        else if (trig) begin m_mode = M_RING; m_secs = 0; end
      end
      M_RING: begin
        if (e[B_STOP]) m_mode = M_ARMED;
        else if (e[B_SNOOZE]) begin m_mode = M_SNOOZE; m_secs = 0; end
        else if (tick) begin
          m_secs++;
          if (m_secs == RING_N) m_mode = M_ARMED;
        end
      end
      M_SNOOZE: begin
        if (e[B_STOP]) m_mode = M_ARMED;
        else if (tick) begin
          m_secs++;
          if (m_secs == SNOOZE_N) begin m_mode = M_RING; m_secs = 0; end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_prev = btns;
  endtask

  // Monitor: one registered snapshot per cycle, popped on the falling edge
  always @(negedge clk) begin
    logic [18:0] want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {a_d3, a_d2, a_d1, a_d0, setting, armed, ringing};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL outputs cyc%0d: got %h:%h%h state(s,a,r)=%b required %h:%h%h state=%b",
                 cyc, got[18:11], got[10:7], got[6:3], got[2:0],
                 want[18:11], want[10:7], want[6:3], want[2:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    exp_q.push_back(pack(m_ah, m_am, m_mode));
    cyc++;
    #1;
  endtask

  task automatic press(int b);
    btns[b] = 1'b1; step();
    btns[b] = 1'b0; step();
  endtask

  task automatic press_n(int b, int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic do_tick(bit z);
    tick = 1'b1; sz = z; step();
    tick = 1'b0; sz = 1'b0; step();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Set alarm to 07:12 and arm
    press(B_SET);
    press_n(B_MIN, 12);
    press_n(B_HORA, 7);
    press(B_SET);

    // Field wrap boundaries inside SET
    press(B_SET);
    press(B_SET);
    press_n(B_MIN, 47);
    press(B_MIN);
    press_n(B_HORA, 16);
    press(B_HORA);
    press_n(B_HORA, 9);
    press(B_HORA);
    btns[B_MIN] = 1'b1; btns[B_HORA] = 1'b1; step();
    btns = '0; step();
    press_n(B_HORA, 20);
    press_n(B_MIN, 11);
    press(B_SET);

    // Trigger, auto-stop, no re-trigger without sec_zero
    t_h = 7; t_m = 12;
    do_tick(1'b1);
    repeat (RING_N) do_tick(1'b0);
    repeat (3) do_tick(1'b0);

    // Trigger, stop after two ticks
    do_tick(1'b1);
    repeat (2) do_tick(1'b0);
    press(B_STOP);

    // Snooze, re-ring, then stop+snooze together
    do_tick(1'b1);
    press(B_SNOOZE);
    repeat (SNOOZE_N) do_tick(1'b0);
    btns[B_STOP] = 1'b1; btns[B_SNOOZE] = 1'b1; step();
    btns = '0; step();

    // Asynchronous reset mid-snooze
    do_tick(1'b1);
    press(B_SNOOZE);
    repeat (2) do_tick(1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_d3, a_d2, a_d1, a_d0, setting, armed, ringing} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h required 00000", {a_d3, a_d2, a_d1, a_d0, setting, armed, ringing});
    end
    step();
    rst_n = 1'b1;
    step();

    // Minute button ignored outside SET
    press(B_MIN);
    press(B_SET);
    press(B_SET);
    press(B_MIN);
    press(B_HORA);
    press(B_SET);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) btns[b] = ~btns[b];
      tick = ($urandom_range(0, 2) == 0);
      sz   = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) begin
        t_h = m_ah; t_m = m_am;
      end else begin
        t_h = int'($urandom_range(0, 23)); t_m = int'($urandom_range(0, 59));
      end
      step();
    end
    btns = '0; tick = 1'b0; sz = 1'b0;
    step();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
